mem_miss_ctrl: RTL and testbench

MEM_MISS_CTRL -- requirements
Module: mem_miss_ctrl

---
 rtl/mem_pkg.sv | 32 +++
 rtl/mem_miss_ctrl_if.sv | 31 +++
 rtl/sat_counter.sv | 38 +++
 rtl/mem_miss_ctrl.sv | 142 ++++++++++++++
 tb/tb_mem_miss_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared constants, state encoding and types for the load-miss controller.
package mem_pkg;

   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int LINE_WORDS = 4;
   localparam int WORD_IDX_W = 2;
   localparam int COUNT_W    = 16;
   localparam int OFFSET_W   = 4;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_REQ    = 3'd1;
   localparam logic [2:0] ST_WAIT   = 3'd2;
   localparam logic [2:0] ST_FILL   = 3'd3;
   localparam logic [2:0] ST_REPLAY = 3'd4;

   typedef logic [ADDR_W-1:0]     addr_t;
   typedef logic [DATA_W-1:0]     data_t;
   typedef logic [WORD_IDX_W-1:0] word_idx_t;
   typedef logic [COUNT_W-1:0]    count_t;

   typedef struct packed {
      logic      we;
      word_idx_t word;
      data_t     data;
   } fill_beat_t;

   function automatic addr_t line_base(input addr_t a);
      return {a[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
   endfunction

endpackage

// File: rtl/mem_miss_ctrl_if.sv
// Pipeline, cache and main-memory signals seen by the load-miss controller.
interface mem_miss_ctrl_if;
   import mem_pkg::*;

   logic      mem_read;
   logic      mem_write;
   addr_t     addr;
   logic      cache_hit;
   logic      mm_ready;
   logic      mm_valid;
   data_t     mm_rdata;
   logic      mm_req;
   addr_t     mm_addr;
   logic      fill_we;
   word_idx_t fill_word;
   data_t     fill_data;
   logic      stall;
   logic      hit_out;
   count_t    miss_count;

   modport master (
      output mem_read, mem_write, addr, cache_hit, mm_ready, mm_valid, mm_rdata,
      input  mm_req, mm_addr, fill_we, fill_word, fill_data, stall, hit_out, miss_count
   );

   modport slave (
      input  mem_read, mem_write, addr, cache_hit, mm_ready, mm_valid, mm_rdata,
      output mm_req, mm_addr, fill_we, fill_word, fill_data, stall, hit_out, miss_count
   );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous clear.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Next count: clear wins, increment only below the ceiling.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = {WIDTH{1'b0}};
      end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
         count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         count_d = count_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= {WIDTH{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/mem_miss_ctrl.sv
// Blocking-cache load-miss controller: stalls the pipe, fetches a 4-word line,
// writes it into the cache word by word, then replays the lookup.
module mem_miss_ctrl
   import mem_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   mem_miss_ctrl_if.slave bus
);

   logic [2:0] state_q, state_d;
   addr_t      base_q, base_d;
   logic       mm_req_q, mm_req_d;
   logic       busy_q, busy_d;
   word_idx_t  beat_q, beat_d;
   fill_beat_t fill_q, fill_d;
   count_t     miss_count_s;

   logic miss_s;
   logic idle_s;
   logic last_write_s;
   logic capture_s;
   logic unused_s;

   assign miss_s       = bus.mem_read & ~bus.cache_hit;
   assign idle_s       = (state_q == ST_IDLE);
   assign last_write_s = fill_q.we & (fill_q.word == word_idx_t'(LINE_WORDS - 1));
   // Once the last word is being written the line is complete; stray beats are dropped.
   assign capture_s    = bus.mm_valid &
                         ((state_q == ST_WAIT) | ((state_q == ST_FILL) & ~last_write_s));

   // Stores are write-through and never reach this block; offset bits are unused.
   assign unused_s = &{1'b0, bus.mem_write, bus.addr[OFFSET_W-1:0]};

   // State transitions and line-base capture.
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      case (state_q)
         ST_IDLE: begin
            if (miss_s) begin
               state_d = ST_REQ;
               base_d  = line_base(bus.addr);
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (bus.mm_ready) begin
               state_d = ST_WAIT;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_WAIT: begin
            if (bus.mm_valid) begin
               state_d = ST_FILL;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_FILL: begin
            if (last_write_s) begin
               state_d = ST_REPLAY;
            end else begin
               state_d = ST_FILL;
            end
         end
         ST_REPLAY: begin
            // A re-lookup that still misses refetches the same line; not a new load miss.
            if (bus.cache_hit) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_REQ;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Fill datapath: register each returned word and strobe it into the cache.
   always_comb begin
      fill_d    = fill_q;
      fill_d.we = 1'b0;
      beat_d    = beat_q;
      if (capture_s) begin
         fill_d.we   = 1'b1;
         fill_d.word = beat_q;
         fill_d.data = bus.mm_rdata;
         beat_d      = beat_q + word_idx_t'(1);
      end else if (state_q == ST_REQ) begin
         beat_d = word_idx_t'(0);
      end else begin
         beat_d = beat_q;
      end
   end

   assign mm_req_d = (state_d == ST_REQ);
   assign busy_d   = (state_d != ST_IDLE);

   // Controller state and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         base_q   <= 32'h0000_0000;
         mm_req_q <= 1'b0;
         busy_q   <= 1'b0;
         beat_q   <= 2'd0;
         fill_q   <= '0;
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         mm_req_q <= mm_req_d;
         busy_q   <= busy_d;
         beat_q   <= beat_d;
         fill_q   <= fill_d;
      end
   end

   sat_counter #(
      .WIDTH (COUNT_W)
   ) u_miss_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (1'b0),
      .inc_i   (idle_s & miss_s),
      .count_o (miss_count_s)
   );

   assign bus.mm_req     = mm_req_q;
   assign bus.mm_addr    = base_q;
   assign bus.fill_we    = fill_q.we;
   assign bus.fill_word  = fill_q.word;
   assign bus.fill_data  = fill_q.data;
   // Only the IDLE-cycle miss detect is combinational, so the pipe freezes in the miss cycle.
   assign bus.stall      = busy_q | (idle_s & miss_s);
   assign bus.hit_out    = ~bus.stall;
   assign bus.miss_count = miss_count_s;

endmodule

// File: tb/tb_mem_miss_ctrl.sv
// Directed self-checking bench for mem_miss_ctrl plus a narrow sat_counter.
module tb_mem_miss_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       sc_clear;
   logic       sc_inc;
   logic [2:0] sc_count;
   int         n_total = 0;
   int         n_pass  = 0;
   int         n_fail  = 0;

   mem_miss_ctrl_if bus();

   mem_miss_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   sat_counter #(
      .WIDTH (3)
   ) u_sc (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (sc_clear),
      .inc_i   (sc_inc),
      .count_o (sc_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic hit);
      bus.mem_read  = rd;
      bus.mem_write = wr;
      bus.addr      = a;
      bus.cache_hit = hit;
   endtask

   initial begin
      rst_n        = 1'b0;
      sc_clear     = 1'b0;
      sc_inc       = 1'b0;
      drive(1'b0, 1'b0, 32'h0000_0000, 1'b0);
      bus.mm_ready = 1'b0;
      bus.mm_valid = 1'b0;
      bus.mm_rdata = 32'h0000_0000;
      #3;
      chk("rst_mm_req",     {31'd0, bus.mm_req},     32'd0);
      chk("rst_fill_we",    {31'd0, bus.fill_we},    32'd0);
      chk("rst_fill_word",  {30'd0, bus.fill_word},  32'd0);
      chk("rst_fill_data",  bus.fill_data,           32'd0);
      chk("rst_miss_count", {16'd0, bus.miss_count}, 32'd0);
      chk("rst_stall",      {31'd0, bus.stall},      32'd0);
      chk("rst_hit_out",    {31'd0, bus.hit_out},    32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      next();

      // load hit
      drive(1'b1, 1'b0, 32'h0000_0100, 1'b1);
      #3;
      chk("hit_stall",   {31'd0, bus.stall},   32'd0);
      chk("hit_hit_out", {31'd0, bus.hit_out}, 32'd1);
      chk("hit_mm_req",  {31'd0, bus.mm_req},  32'd0);
      next();
      chk("hit_miss_count", {16'd0, bus.miss_count}, 32'd0);

      // store miss
      drive(1'b0, 1'b1, 32'h0000_2000, 1'b0);
      #3;
      chk("st_stall",   {31'd0, bus.stall},   32'd0);
      chk("st_hit_out", {31'd0, bus.hit_out}, 32'd1);
      next();
      chk("st_mm_req",     {31'd0, bus.mm_req},     32'd0);
      chk("st_miss_count", {16'd0, bus.miss_count}, 32'd0);

      // load miss at 0x1234 with read+write both high
      drive(1'b1, 1'b1, 32'h0000_1234, 1'b0);
      #3;
      chk("miss_stall",   {31'd0, bus.stall},   32'd1);
      chk("miss_hit_out", {31'd0, bus.hit_out}, 32'd0);
      chk("miss_mm_req0", {31'd0, bus.mm_req},  32'd0);
      next();
      chk("req1_mm_req",     {31'd0, bus.mm_req},     32'd1);
      chk("req1_mm_addr",    bus.mm_addr,             32'h0000_1230);
      chk("req1_miss_count", {16'd0, bus.miss_count}, 32'd1);
      drive(1'b0, 1'b0, 32'hFFFF_FFF0, 1'b0);
      bus.mm_valid = 1'b1;
      bus.mm_rdata = 32'h0000_DEAD;
      #3;
      chk("req1_stall",   {31'd0, bus.stall},   32'd1);
      chk("req1_hit_out", {31'd0, bus.hit_out}, 32'd0);
      next();
      bus.mm_valid = 1'b0;
      chk("req2_mm_req",  {31'd0, bus.mm_req},  32'd1);
      chk("req2_mm_addr", bus.mm_addr,          32'h0000_1230);
      chk("req2_fill_we", {31'd0, bus.fill_we}, 32'd0);
      next();
      chk("req3_mm_req", {31'd0, bus.mm_req}, 32'd1);
      bus.mm_ready = 1'b1;
      next();
      bus.mm_ready = 1'b0;
      chk("wait_mm_req", {31'd0, bus.mm_req}, 32'd0);
      chk("wait_stall",  {31'd0, bus.stall},  32'd1);

      // beats at cycles 0,1,3,4
      bus.mm_valid = 1'b1;
      bus.mm_rdata = 32'h0000_00A0;
      next();
      chk("w0_we",   {31'd0, bus.fill_we},   32'd1);
      chk("w0_word", {30'd0, bus.fill_word}, 32'd0);
      chk("w0_data", bus.fill_data,          32'h0000_00A0);
      bus.mm_rdata = 32'h0000_00A1;
      next();
      chk("w1_we",   {31'd0, bus.fill_we},   32'd1);
      chk("w1_word", {30'd0, bus.fill_word}, 32'd1);
      chk("w1_data", bus.fill_data,          32'h0000_00A1);
      bus.mm_valid = 1'b0;
      next();
      chk("gap_we",   {31'd0, bus.fill_we},   32'd0);
      chk("gap_word", {30'd0, bus.fill_word}, 32'd1);
      bus.mm_valid = 1'b1;
      bus.mm_rdata = 32'h0000_00A2;
      next();
      chk("w2_we",   {31'd0, bus.fill_we},   32'd1);
      chk("w2_word", {30'd0, bus.fill_word}, 32'd2);
      chk("w2_data", bus.fill_data,          32'h0000_00A2);
      bus.mm_rdata = 32'h0000_00A3;
      next();
      chk("w3_we",    {31'd0, bus.fill_we},   32'd1);
      chk("w3_word",  {30'd0, bus.fill_word}, 32'd3);
      chk("w3_data",  bus.fill_data,          32'h0000_00A3);
      chk("w3_stall", {31'd0, bus.stall},     32'd1);
      bus.mm_valid = 1'b0;
      drive(1'b1, 1'b0, 32'h0000_1234, 1'b1);
      next();
      chk("replay_we",      {31'd0, bus.fill_we}, 32'd0);
      chk("replay_stall",   {31'd0, bus.stall},   32'd1);
      chk("replay_hit_out", {31'd0, bus.hit_out}, 32'd0);
      chk("replay_mm_req",  {31'd0, bus.mm_req},  32'd0);
      next();
      chk("done_stall",      {31'd0, bus.stall},      32'd0);
      chk("done_hit_out",    {31'd0, bus.hit_out},    32'd1);
      chk("done_miss_count", {16'd0, bus.miss_count}, 32'd1);

      // reset during fill word 2
      drive(1'b1, 1'b0, 32'h0000_2008, 1'b0);
      next();
      chk("m2_mm_addr",    bus.mm_addr,             32'h0000_2000);
      chk("m2_miss_count", {16'd0, bus.miss_count}, 32'd2);
      bus.mm_ready = 1'b1;
      next();
      bus.mm_ready = 1'b0;
      bus.mm_valid = 1'b1;
      bus.mm_rdata = 32'h0000_00B0;
      next();
      bus.mm_rdata = 32'h0000_00B1;
      next();
      bus.mm_rdata = 32'h0000_00B2;
      next();
      chk("m2_w2_word", {30'd0, bus.fill_word}, 32'd2);
      bus.mm_valid = 1'b0;
      drive(1'b0, 1'b0, 32'h0000_0000, 1'b0);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_fill_we",    {31'd0, bus.fill_we},    32'd0);
      chk("arst_fill_word",  {30'd0, bus.fill_word},  32'd0);
      chk("arst_fill_data",  bus.fill_data,           32'd0);
      chk("arst_mm_req",     {31'd0, bus.mm_req},     32'd0);
      chk("arst_mm_addr",    bus.mm_addr,             32'd0);
      chk("arst_miss_count", {16'd0, bus.miss_count}, 32'd0);
      chk("arst_stall",      {31'd0, bus.stall},      32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      next();

      // restart after reset, then replay that still misses
      drive(1'b1, 1'b0, 32'h0000_3004, 1'b0);
      #3;
      chk("m3_stall", {31'd0, bus.stall}, 32'd1);
      next();
      chk("m3_mm_req",     {31'd0, bus.mm_req},     32'd1);
      chk("m3_mm_addr",    bus.mm_addr,             32'h0000_3000);
      chk("m3_miss_count", {16'd0, bus.miss_count}, 32'd1);
      bus.mm_ready = 1'b1;
      next();
      bus.mm_ready = 1'b0;
      bus.mm_valid = 1'b1;
      bus.mm_rdata = 32'h0000_00C0;
      next();
      chk("m3_w0_we",   {31'd0, bus.fill_we},   32'd1);
      chk("m3_w0_word", {30'd0, bus.fill_word}, 32'd0);
      chk("m3_w0_data", bus.fill_data,          32'h0000_00C0);
      bus.mm_rdata = 32'h0000_00C1;
      next();
      bus.mm_rdata = 32'h0000_00C2;
      next();
      bus.mm_rdata = 32'h0000_00C3;
      next();
      chk("m3_w3_word", {30'd0, bus.fill_word}, 32'd3);
      bus.mm_valid = 1'b0;
      next();
      chk("m3_replay_stall", {31'd0, bus.stall}, 32'd1);
      next();
      chk("m3_rereq_mm_req",  {31'd0, bus.mm_req}, 32'd1);
      chk("m3_rereq_mm_addr", bus.mm_addr,         32'h0000_3000);

      // saturation on a 3-bit counter instance
      sc_inc = 1'b1;
      repeat (6) next();
      chk("sc_six", {29'd0, sc_count}, 32'd6);
      repeat (4) next();
      chk("sc_sat", {29'd0, sc_count}, 32'd7);
      sc_inc   = 1'b0;
      sc_clear = 1'b1;
      next();
      sc_clear = 1'b0;
      chk("sc_clear", {29'd0, sc_count}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
